// File: rtl/alu_issue.sv
// alu_issue: RV32I OP/OP-IMM issue, ALU drive and register writeback controller
// ALU_ISSUE_FAST_EN: removes WB; write back and report directly from EXEC
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  output logic [31:0] o_lhs,
  output logic        o_lhs_valid,
  output logic [31:0] o_rhs,
  output logic        o_rhs_valid,
  output logic [2:0]  o_operation,
  output logic        o_operation_valid,
  output logic [6:0]  o_metadata,
  output logic        o_metadata_valid,
  input  logic [31:0] i_result,
  input  logic        i_result_valid,
  output logic        o_done,
  output logic [4:0]  o_done_rd,
  output logic [31:0] o_done_value,
  output logic        o_illegal,
  input  logic [4:0]  i_dbg_addr,
  output logic [31:0] o_dbg_data
);
`ifdef ALU_ISSUE_FAST_EN
  typedef enum logic {IDLE, EXEC} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
`endif
  state_t r_state, w_next;
  logic [31:0] r_instr;
  logic [31:0] r_rf [32];
  logic r_illegal;
  logic w_accept, w_legal_in, w_exec, w_op, w_we, w_reject;
  logic [4:0] w_rd;
  logic [31:0] w_wdata;
  assign w_accept   = o_instr_ready && i_instr_valid;
  assign w_legal_in = i_instr[6:0] == 7'b0110011 || i_instr[6:0] == 7'b0010011;
  assign w_exec     = r_state == EXEC;
  assign w_op       = r_instr[6:0] == 7'b0110011;
  assign w_rd       = r_instr[11:7];
  assign o_dbg_data = r_rf[i_dbg_addr];
`ifdef ALU_ISSUE_FAST_EN
  always_comb begin
    w_next        = (r_state == IDLE && w_accept && w_legal_in) ? EXEC : IDLE;
    o_instr_ready = r_state == IDLE;
  end
  assign o_done       = w_exec && i_result_valid;
  assign o_done_rd    = o_done ? w_rd : 5'd0;
  assign o_done_value = o_done ? i_result : 32'd0;
  assign o_illegal    = r_illegal || (w_exec && !i_result_valid);
  assign w_reject     = 1'b0;
  assign w_we         = o_done;
  assign w_wdata      = i_result;
`else
  logic [31:0] r_result;
  always_comb begin
    w_next        = (r_state == IDLE) ? ((w_accept && w_legal_in) ? EXEC : IDLE) :
                    (w_exec && i_result_valid) ? WB : IDLE;
    o_instr_ready = r_state == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_result <= '0;
    else if (w_exec) r_result <= i_result;
  assign o_done       = r_state == WB;
  assign o_done_rd    = o_done ? w_rd : 5'd0;
  assign o_done_value = o_done ? r_result : 32'd0;
  assign o_illegal    = r_illegal;
  assign w_reject     = w_exec && !i_result_valid;
  assign w_we         = o_done;
  assign w_wdata      = r_result;
`endif
  assign o_lhs_valid       = w_exec;
  assign o_rhs_valid       = w_exec;
  assign o_operation_valid = w_exec;
  assign o_metadata_valid  = w_exec;
  assign o_lhs       = w_exec ? r_rf[r_instr[19:15]] : 32'd0;
  assign o_rhs       = !w_exec ? 32'd0 : w_op ? r_rf[r_instr[24:20]] : {{20{r_instr[31]}}, r_instr[31:20]};
  assign o_operation = w_exec ? r_instr[14:12] : 3'd0;
  // OP-IMM only carries imm[11:5] for shifts (funct3 x01); otherwise force 0 so ADDI never subtracts
  assign o_metadata  = (w_exec && (w_op || r_instr[13:12] == 2'b01)) ? r_instr[31:25] : 7'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_instr   <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) r_instr <= i_instr;
      r_illegal <= (w_accept && !w_legal_in) || w_reject;
    end
  // x0 is only ever cleared by reset, so it always reads back as zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) r_rf[k] <= '0;
    end else if (w_we && w_rd != 5'd0) begin
      r_rf[w_rd] <= w_wdata;
    end
endmodule
